intpol2_frame_sequencer: RTL and testbench

Sequencing controller for the intpol2_D4_CORE IQ quadratic interpolator and its output sink. It holds the four 32-bit configuration words plus signal length and frame count, validates them, and computes the expected output sample count. It pulses start to the core and sink once per frame and counts samples drained from the output FIFO. It reports frame and run completion, and aborts on a stall watchdog.

---
 rtl/intpol2_pkg.sv | 37 +++
 rtl/intpol2_seq_regfile.sv | 88 ++++++++
 rtl/intpol2_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_intpol2_frame_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intpol2_pkg.sv
// Shared types and constants for the intpol2 frame sequencer: FSM states,
// register map indices, error codes and status word bit positions.
package intpol2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_FEND,
    S_GAP,
    S_DONE,
    S_ERR
  } seq_state_e;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_IX        = 3'd1;
  localparam logic [2:0] REG_IX2       = 3'd2;
  localparam logic [2:0] REG_ILEN      = 3'd3;
  localparam logic [2:0] REG_SIG_LEN   = 3'd4;
  localparam logic [2:0] REG_N_FRAMES  = 3'd5;
  localparam logic [2:0] REG_STATUS    = 3'd6;
  localparam logic [2:0] REG_TOTAL_LEN = 3'd7;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CFG  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int ST_ALL_DONE    = 0;
  localparam int ST_BUSY        = 1;
  localparam int ST_ERR         = 2;
  localparam int ST_WR_BUSY     = 3;
  localparam int ST_ERR_CODE_LO = 4;
  localparam int ST_FRAMES_LO   = 8;

endpackage

// File: rtl/intpol2_seq_regfile.sv
// Configuration/status register file for the frame sequencer: write guard
// while a run is active, sticky write-while-busy flag and combinational read mux.
module intpol2_seq_regfile
  import intpol2_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int FRAMES_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [2:0]              addr,
  input  logic [CONFIG_WIDTH-1:0] wdata,
  output logic [CONFIG_WIDTH-1:0] rdata,
  input  logic                    busy,
  input  logic                    all_done,
  input  logic                    err,
  input  logic [1:0]              err_code,
  input  logic [FRAMES_WIDTH-1:0] frames_left,
  input  logic [ADDR_WIDTH-1:0]   total_len,
  output logic [CONFIG_WIDTH-1:0] ctrl,
  output logic [CONFIG_WIDTH-1:0] ix,
  output logic [CONFIG_WIDTH-1:0] ix2,
  output logic [CONFIG_WIDTH-1:0] ilen,
  output logic [ADDR_WIDTH-1:0]   sig_len,
  output logic [FRAMES_WIDTH-1:0] n_frames
);

  logic                    wr_busy;
  logic [CONFIG_WIDTH-1:0] status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      ix       <= '0;
      ix2      <= '0;
      ilen     <= '0;
      sig_len  <= '0;
      n_frames <= '0;
      wr_busy  <= 1'b0;
    end else if (we) begin
      // Config must stay frozen for the whole run, so busy writes are dropped.
      if (busy) begin
        wr_busy <= 1'b1;
      end else begin
        case (addr)
          REG_CTRL: begin
            ctrl    <= wdata;
            wr_busy <= 1'b0;
          end
          REG_IX:       ix       <= wdata;
          REG_IX2:      ix2      <= wdata;
          REG_ILEN:     ilen     <= wdata;
          REG_SIG_LEN:  sig_len  <= wdata[ADDR_WIDTH-1:0];
          REG_N_FRAMES: n_frames <= wdata[FRAMES_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status = '0;
    status[ST_ALL_DONE] = all_done;
    status[ST_BUSY]     = busy;
    status[ST_ERR]      = err;
    status[ST_WR_BUSY]  = wr_busy;
    status[ST_ERR_CODE_LO +: 2]           = err_code;
    status[ST_FRAMES_LO +: FRAMES_WIDTH]  = frames_left;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:      rdata = ctrl;
      REG_IX:        rdata = ix;
      REG_IX2:       rdata = ix2;
      REG_ILEN:      rdata = ilen;
      REG_SIG_LEN:   rdata = CONFIG_WIDTH'(sig_len);
      REG_N_FRAMES:  rdata = CONFIG_WIDTH'(n_frames);
      REG_STATUS:    rdata = status;
      REG_TOTAL_LEN: rdata = CONFIG_WIDTH'(total_len);
      default:       rdata = '0;
    endcase
  end

endmodule

// File: rtl/intpol2_frame_sequencer.sv
// Run controller for the intpol2 IQ interpolator: validates config, pulses
// core/sink start per frame, counts drained samples and guards against stalls.
module intpol2_frame_sequencer
  import intpol2_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int FRAMES_WIDTH = 8,
  parameter int WDOG_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [CONFIG_WIDTH-1:0]   cfg_wdata,
  output logic [CONFIG_WIDTH-1:0]   cfg_rdata,
  input  logic                      go,
  input  logic                      abort,
  input  logic [7:0]                core_status_i,
  input  logic                      out_empty_i,
  input  logic                      out_re_i,
  output logic [4*CONFIG_WIDTH-1:0] config_reg_o,
  output logic                      core_start_o,
  output logic                      sink_start_o,
  output logic [ADDR_WIDTH-1:0]     sink_len_o,
  output logic                      frame_done_o,
  output logic                      all_done_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int PROD_W = CONFIG_WIDTH + ADDR_WIDTH;

  logic [CONFIG_WIDTH-1:0] ctrl, ix, ix2, ilen;
  logic [ADDR_WIDTH-1:0]   sig_len;
  logic [FRAMES_WIDTH-1:0] n_frames;

  seq_state_e              state, state_nxt;
  logic [1:0]              err_code, err_nxt;
  logic [FRAMES_WIDTH-1:0] frames_left;
  logic [ADDR_WIDTH-1:0]   total_len, cnt, cnt_inc;
  logic [WDOG_WIDTH-1:0]   wdog;
  logic                    done_seen;
  logic [PROD_W-1:0]       prod;
  logic                    ovf, pop, run_pop, wdog_expired, state_busy;
  logic                    core_done, core_busy;
  logic                    unused_status;

  intpol2_seq_regfile #(
    .CONFIG_WIDTH(CONFIG_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .FRAMES_WIDTH(FRAMES_WIDTH)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we         (cfg_we),
    .addr       (cfg_addr),
    .wdata      (cfg_wdata),
    .rdata      (cfg_rdata),
    .busy       (busy_o),
    .all_done   (all_done_o),
    .err        (err_o),
    .err_code   (err_code),
    .frames_left(frames_left),
    .total_len  (total_len),
    .ctrl       (ctrl),
    .ix         (ix),
    .ix2        (ix2),
    .ilen       (ilen),
    .sig_len    (sig_len),
    .n_frames   (n_frames)
  );

  assign config_reg_o = {ilen, ix2, ix, ctrl};
  assign sink_len_o   = total_len;

  assign core_done     = core_status_i[0];
  assign core_busy     = core_status_i[1];
  assign unused_status = ^core_status_i[7:2];

  // Full-width product so any length that does not fit ADDR_WIDTH is caught.
  assign prod = (PROD_W'(sig_len) - PROD_W'(2)) * PROD_W'(ilen);
  assign ovf  = |prod[PROD_W-1:ADDR_WIDTH];

  assign pop          = out_re_i & ~out_empty_i;
  assign run_pop      = pop & (state == S_RUN);
  assign cnt_inc      = cnt + ADDR_WIDTH'(run_pop);
  assign wdog_expired = (wdog == '1) & ~pop;
  assign state_busy   = !(state inside {S_IDLE, S_DONE, S_ERR});

  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (ilen == '0 || sig_len < ADDR_WIDTH'(3) || n_frames == '0) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_BAD_CFG;
        end else if (ovf) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_OVERFLOW;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (cnt_inc == total_len && (done_seen || core_done)) begin
          state_nxt = S_FEND;
        end else if (wdog_expired) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      S_FEND: state_nxt = (frames_left != FRAMES_WIDTH'(1)) ? S_GAP : S_DONE;
      S_GAP: begin
        if (!core_busy && out_empty_i) begin
          state_nxt = S_START;
        end else if (wdog_expired) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state_busy) begin
      state_nxt = S_IDLE;
      err_nxt   = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      core_start_o <= 1'b0;
      sink_start_o <= 1'b0;
      frame_done_o <= 1'b0;
      all_done_o   <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code     <= ERR_NONE;
      frames_left  <= '0;
      total_len    <= '0;
      cnt          <= '0;
      wdog         <= '0;
      done_seen    <= 1'b0;
    end else begin
      state        <= state_nxt;
      core_start_o <= (state_nxt == S_START);
      sink_start_o <= (state_nxt == S_START);
      frame_done_o <= (state_nxt == S_FEND);
      all_done_o   <= (state_nxt == S_DONE);
      err_o        <= (state_nxt == S_ERR);
      busy_o       <= !(state_nxt inside {S_IDLE, S_DONE, S_ERR});

      if (state == S_CHECK) total_len <= prod[ADDR_WIDTH-1:0];

      if (state_nxt == S_CHECK) err_code <= ERR_NONE;
      else if (state_nxt == S_ERR && state != S_ERR) err_code <= err_nxt;

      if (state == S_CHECK && state_nxt == S_START) frames_left <= n_frames;
      else if (state == S_FEND) frames_left <= frames_left - FRAMES_WIDTH'(1);

      cnt <= (state_nxt == S_START) ? '0 : cnt_inc;

      // Done may arrive before or after the last pop; remember it per frame.
      if (state_nxt == S_START) done_seen <= 1'b0;
      else if (core_done) done_seen <= 1'b1;

      if (state_nxt != state || pop) wdog <= '0;
      else if (state == S_RUN || state == S_GAP) wdog <= wdog + WDOG_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_intpol2_frame_sequencer.sv
// Scoreboard bench for intpol2_frame_sequencer: stimulus queues expected
// output events, a negedge monitor pops and compares them as they appear.
module tb_intpol2_frame_sequencer;

  localparam int EV_START = 1;
  localparam int EV_FEND  = 2;
  localparam int EV_ERR   = 3;
  localparam int EV_DONE  = 4;
  localparam int EV_IDLE  = 5;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [31:0]  cfg_rdata;
  logic         go, abort;
  logic [7:0]   core_status;
  logic         out_empty, out_re;
  logic [127:0] config_reg_o;
  logic         core_start_o, sink_start_o, frame_done_o, all_done_o, busy_o, err_o;
  logic [19:0]  sink_len_o;

  ev_t q[$];
  int  n_checks = 0;
  int  n_errs   = 0;

  intpol2_frame_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .go           (go),
    .abort        (abort),
    .core_status_i(core_status),
    .out_empty_i  (out_empty),
    .out_re_i     (out_re),
    .config_reg_o (config_reg_o),
    .core_start_o (core_start_o),
    .sink_start_o (sink_start_o),
    .sink_len_o   (sink_len_o),
    .frame_done_o (frame_done_o),
    .all_done_o   (all_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ev(input int kind, input logic [31:0] act);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errs++;
      $display("FAIL unexpected_event: kind %0d data 0x%08h with nothing expected", kind, act);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== act) begin
        n_errs++;
        $display("FAIL event: got kind %0d data 0x%08h expected kind %0d data 0x%08h",
                 kind, act, e.kind, e.data);
      end
    end
  endtask

  function automatic logic [31:0] start_word(input logic [7:0] fl, input logic [19:0] len);
    return {fl, 1'b0, 1'b1, 1'b1, 1'b0, len};
  endfunction

  // Monitor: events use state before this cycle's pop is counted.
  logic prev_err = 1'b0, prev_done = 1'b0, prev_busy = 1'b0, prev_block = 1'b0;
  int   pop_cnt = 0;
  always @(negedge clk) begin
    if (core_start_o || sink_start_o) begin
      ev(EV_START, {cfg_rdata[15:8], prev_block, core_start_o, sink_start_o, 1'b0, sink_len_o});
      pop_cnt = 0;
    end
    if (frame_done_o) ev(EV_FEND, 32'(pop_cnt));
    if (err_o && !prev_err) ev(EV_ERR, 32'(cfg_rdata[5:4]));
    if (all_done_o && !prev_done) ev(EV_DONE, 32'(cfg_rdata[15:8]));
    if (!busy_o && prev_busy && !err_o && !all_done_o) ev(EV_IDLE, 32'(frame_done_o));
    if (out_re && !out_empty) pop_cnt++;
    prev_err   = err_o;
    prev_done  = all_done_o;
    prev_busy  = busy_o;
    prev_block = core_status[1] || !out_empty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 3'd6;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] il, input logic [31:0] sl, input logic [31:0] nf);
    wr(3'd3, il);
    wr(3'd4, sl);
    wr(3'd5, nf);
  endtask

  task automatic run_pops(input int n, input int done_after, input int wr_at);
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        out_re = 1'b0;
        wr(3'd1, 32'hDEAD_BEEF);
        #1;
        chk("ix_kept_while_busy", config_reg_o[63:32], 32'h1234_5678);
        chk("wr_while_busy_set", 32'(cfg_rdata[3]), 32'd1);
      end
      if (i == done_after) core_status = 8'h01;
      out_re = 1'b1; out_empty = 1'b0;
      tick();
    end
    out_re = 1'b0;
  endtask

  int tbl_ilen[5] = '{0, 4, 4, 4096, 4096};
  int tbl_sig[5]  = '{12, 2, 12, 514, 258};
  int tbl_nf[5]   = '{1, 1, 0, 1, 1};
  int tbl_code[5] = '{1, 1, 1, 2, 2};

  initial begin
    int n;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd6; cfg_wdata = '0;
    go = 1'b0; abort = 1'b0; core_status = 8'h00; out_empty = 1'b1; out_re = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {26'b0, core_start_o, sink_start_o, frame_done_o, all_done_o, busy_o, err_o}, 32'd0);
    chk("rst_status", cfg_rdata, 32'd0);
    chk("rst_config", 32'(config_reg_o == 128'd0), 32'd1);
    rst = 1'b0;
    tick();

    // Single frame: 10 x (12-2) = 100 samples, done after pop 90
    cfg(32'd10, 32'd12, 32'd1);
    cfg_addr = 3'd3; #1;
    chk("rd_ilen", cfg_rdata, 32'd10);
    cfg_addr = 3'd6;
    q.push_back('{EV_START, start_word(8'd1, 20'd100)});
    q.push_back('{EV_FEND, 32'd100});
    q.push_back('{EV_DONE, 32'd0});
    pulse_go();
    repeat (2) tick();
    run_pops(100, 90, -1);
    out_empty = 1'b1;
    repeat (3) tick();
    chk("single_all_done", 32'(all_done_o), 32'd1);
    cfg_addr = 3'd7; #1;
    chk("total_len", cfg_rdata, 32'd100);
    cfg_addr = 3'd6;
    core_status = 8'h00;

    // Invalid configurations: bad cfg and overflow (including exactly 2**20)
    for (int r = 0; r < 5; r++) begin
      cfg(32'(tbl_ilen[r]), 32'(tbl_sig[r]), 32'(tbl_nf[r]));
      q.push_back('{EV_ERR, 32'(tbl_code[r])});
      pulse_go();
      repeat (3) tick();
    end

    // Fix and re-run from ERR, then abort mid-RUN
    cfg(32'd4, 32'd12, 32'd1);
    q.push_back('{EV_START, start_word(8'd1, 20'd40)});
    q.push_back('{EV_IDLE, 32'd0});
    pulse_go();
    chk("err_cleared_in_check", 32'(err_o), 32'd0);
    repeat (2) tick();
    run_pops(5, -1, -1);
    out_empty = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_no_done", {30'b0, all_done_o, frame_done_o}, 32'd0);
    repeat (2) tick();

    // Three frames of 16, GAP held by core busy and non-empty FIFO
    wr(3'd1, 32'h1234_5678);
    cfg(32'd2, 32'd10, 32'd3);
    q.push_back('{EV_START, start_word(8'd3, 20'd16)});
    q.push_back('{EV_FEND, 32'd16});
    q.push_back('{EV_START, start_word(8'd2, 20'd16)});
    q.push_back('{EV_FEND, 32'd16});
    q.push_back('{EV_START, start_word(8'd1, 20'd16)});
    q.push_back('{EV_FEND, 32'd16});
    q.push_back('{EV_DONE, 32'd0});
    pulse_go();
    repeat (2) tick();
    for (int f = 0; f < 3; f++) begin
      run_pops(16, 8, (f == 0) ? 4 : -1);
      out_empty = 1'b0; core_status = 8'h02;
      repeat (5) tick();
      core_status = 8'h00; out_empty = 1'b1;
      repeat (2) tick();
    end
    chk("multi_all_done", 32'(all_done_o), 32'd1);
    wr(3'd0, 32'h0000_0001);
    #1;
    chk("wr_while_busy_cleared", 32'(cfg_rdata[3]), 32'd0);
    chk("ctrl_written", config_reg_o[31:0], 32'd1);

    // Watchdog: stop popping mid-frame
    cfg(32'd2, 32'd10, 32'd1);
    q.push_back('{EV_START, start_word(8'd1, 20'd16)});
    q.push_back('{EV_ERR, 32'd3});
    pulse_go();
    repeat (2) tick();
    run_pops(3, -1, -1);
    out_empty = 1'b1;
    n = 0;
    while (!err_o && n < 70000) begin
      tick();
      n++;
    end
    chk("wdog_timeout_window", 32'(n >= 65530 && n <= 65540), 32'd1);

    // Asynchronous reset mid-RUN
    q.push_back('{EV_START, start_word(8'd1, 20'd16)});
    q.push_back('{EV_IDLE, 32'd0});
    pulse_go();
    repeat (2) tick();
    run_pops(3, -1, -1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_run_outputs", {26'b0, core_start_o, sink_start_o, frame_done_o, all_done_o, busy_o, err_o}, 32'd0);
    chk("rst_mid_run_config", 32'(config_reg_o == 128'd0), 32'd1);
    chk("rst_mid_run_sink_len", 32'(sink_len_o), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
